// File: rtl/motion_segment_sequencer.sv
// Plays out a four-segment motion profile (accel, cruise, decel, tail) in real time,
// producing the current segment, elapsed ticks and commanded speed.
module motion_segment_sequencer #(
    parameter int TW = 64,
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [TW-1:0] max_timing [0:3],
    input  logic [PW-1:0] max_params [0:4],
    input  logic          tick_en,
    output logic          busy,
    output logic [2:0]    seg,
    output logic          seg_first,
    output logic [TW-1:0] elapsed,
    output logic [PW-1:0] speed,
    output logic [PW-1:0] steps,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic [2:0]    seg_q, seg_d;
    logic          seg_first_q, seg_first_d;
    logic [TW-1:0] elapsed_q, elapsed_d;
    logic [PW-1:0] speed_q, speed_d;
    logic [PW-1:0] steps_q, steps_d;
    logic          done_q, done_d;
    logic [TW-1:0] t_q [0:3];
    logic [TW-1:0] t_d [0:3];
    logic [PW-1:0] vmin_q, vmin_d;
    logic [PW-1:0] vmax_q, vmax_d;
    logic [PW-1:0] acc_q, acc_d;
    logic          clear_outs;

    // Jerk is carried by the upstream bus but has no role in playback.
    logic unused_jerk;
    assign unused_jerk = ^max_params[4];

    // Sum formed one bit wider so a large acc can never wrap past vmax.
    function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] v,
                                              input logic [PW-1:0] a,
                                              input logic [PW-1:0] hi);
        logic [PW:0] sum;
        sum = {1'b0, v} + {1'b0, a};
        return (sum > {1'b0, hi}) ? hi : sum[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] sat_sub(input logic [PW-1:0] v,
                                              input logic [PW-1:0] a,
                                              input logic [PW-1:0] lo);
        logic [PW:0] floor_sum;
        floor_sum = {1'b0, lo} + {1'b0, a};
        return ({1'b0, v} < floor_sum) ? lo : v - a;
    endfunction

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        seg_d       = seg_q;
        seg_first_d = 1'b0;
        elapsed_d   = elapsed_q;
        speed_d     = speed_q;
        steps_d     = steps_q;
        done_d      = done_q;
        vmin_d      = vmin_q;
        vmax_d      = vmax_q;
        acc_d       = acc_q;
        for (int k = 0; k < 4; k++) t_d[k] = t_q[k];
        clear_outs  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && in_valid) begin
                    for (int k = 0; k < 4; k++) t_d[k] = max_timing[k];
                    steps_d     = max_params[0];
                    vmin_d      = max_params[1];
                    vmax_d      = max_params[2];
                    acc_d       = max_params[3];
                    speed_d     = max_params[1];
                    elapsed_d   = '0;
                    seg_d       = 3'd0;
                    seg_first_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (!start) begin
                    clear_outs = 1'b1;
                end else if (elapsed_q >= t_q[seg_q[1:0]]) begin
                    // Segment boundary costs one clk and no tick, so empty segments still pulse.
                    seg_d       = seg_q + 3'd1;
                    seg_first_d = 1'b1;
                    if (seg_q == 3'd3) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (tick_en) begin
                    elapsed_d = elapsed_q + TW'(1);
                    case (seg_q)
                        3'd0:    speed_d = sat_add(speed_q, acc_q, vmax_q);
                        3'd2:    speed_d = sat_sub(speed_q, acc_q, vmin_q);
                        default: speed_d = speed_q;
                    endcase
                end
            end
            S_DONE: begin
                if (!start) clear_outs = 1'b1;
            end
            default: clear_outs = 1'b1;
        endcase

        if (clear_outs) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            seg_d       = 3'd0;
            seg_first_d = 1'b0;
            elapsed_d   = '0;
            speed_d     = '0;
            steps_d     = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            seg_q       <= 3'd0;
            seg_first_q <= 1'b0;
            elapsed_q   <= '0;
            speed_q     <= '0;
            steps_q     <= '0;
            done_q      <= 1'b0;
            vmin_q      <= '0;
            vmax_q      <= '0;
            acc_q       <= '0;
            for (int k = 0; k < 4; k++) t_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            seg_q       <= seg_d;
            seg_first_q <= seg_first_d;
            elapsed_q   <= elapsed_d;
            speed_q     <= speed_d;
            steps_q     <= steps_d;
            done_q      <= done_d;
            vmin_q      <= vmin_d;
            vmax_q      <= vmax_d;
            acc_q       <= acc_d;
            for (int k = 0; k < 4; k++) t_q[k] <= t_d[k];
        end
    end

    assign busy      = busy_q;
    assign seg       = seg_q;
    assign seg_first = seg_first_q;
    assign elapsed   = elapsed_q;
    assign speed     = speed_q;
    assign steps     = steps_q;
    assign done      = done_q;

endmodule

// File: tb/tb_motion_segment_sequencer.sv
// Bench for motion_segment_sequencer: directed profiles plus randomized profiles,
// each clk compared against a behavioural model of the segment walk.
module tb_motion_segment_sequencer;
    localparam int TW = 64;
    localparam int PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, in_valid, tick_en;
    logic [TW-1:0] max_timing [0:3];
    logic [PW-1:0] max_params [0:4];
    logic          busy, seg_first, done;
    logic [2:0]    seg;
    logic [TW-1:0] elapsed;
    logic [PW-1:0] speed, steps;

    motion_segment_sequencer #(.TW(TW), .PW(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .max_timing(max_timing), .max_params(max_params), .tick_en(tick_en),
        .busy(busy), .seg(seg), .seg_first(seg_first), .elapsed(elapsed),
        .speed(speed), .steps(steps), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model
    int              m_phase;   // 0 waiting, 1 playing, 2 finished
    longint unsigned m_t [4];
    longint          m_vmin, m_vmax, m_acc, m_speed;
    longint unsigned m_steps, m_el;
    int              m_seg;
    bit              m_busy, m_first, m_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_clear();
        m_phase = 0; m_busy = 0; m_seg = 0; m_first = 0;
        m_el = 0; m_speed = 0; m_steps = 0; m_done = 0;
    endtask

    task automatic model_edge();
        longint nxt;
        if (reset) begin
            model_clear();
        end else if (m_phase == 0) begin
            m_first = 0;
            if (start && in_valid) begin
                for (int k = 0; k < 4; k++) m_t[k] = max_timing[k];
                m_steps = max_params[0];
                m_vmin  = longint'(max_params[1]);
                m_vmax  = longint'(max_params[2]);
                m_acc   = longint'(max_params[3]);
                m_speed = m_vmin; m_el = 0; m_seg = 0;
                m_first = 1; m_busy = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_first = 0;
            if (!start) model_clear();
            else if (m_el >= m_t[m_seg]) begin
                m_seg++;
                m_first = 1;
                if (m_seg == 4) begin m_busy = 0; m_done = 1; m_phase = 2; end
            end else if (tick_en) begin
                m_el++;
                if (m_seg == 0) begin
                    nxt = m_speed + m_acc;
                    m_speed = (nxt > m_vmax) ? m_vmax : nxt;
                end else if (m_seg == 2) begin
                    nxt = m_speed - m_acc;
                    m_speed = (nxt < m_vmin) ? m_vmin : nxt;
                end
            end
        end else begin
            m_first = 0;
            if (!start) model_clear();
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", busy, m_busy);
        chk("seg", seg, m_seg);
        chk("seg_first", seg_first, m_first);
        chk("elapsed", elapsed, m_el);
        chk("speed", speed, m_speed);
        chk("steps", steps, m_steps);
        chk("done", done, m_done);
    endtask

    task automatic load(input longint t0, input longint t1, input longint t2, input longint t3,
                        input int unsigned vmin, input int unsigned vmax,
                        input int unsigned acc, input int unsigned stp);
        max_timing[0] = t0; max_timing[1] = t1; max_timing[2] = t2; max_timing[3] = t3;
        max_params[0] = stp; max_params[1] = vmin; max_params[2] = vmax;
        max_params[3] = acc; max_params[4] = $urandom;
    endtask

    logic [PW-1:0] q0[$];
    logic [PW-1:0] q2[$];

    task automatic chk_list(input string tag, input logic [PW-1:0] q[$],
                            input int e0, input int e1, input int e2);
        chk({tag, "_len"}, q.size(), 3);
        if (q.size() >= 3) begin
            chk({tag, "_0"}, q[0], e0);
            chk({tag, "_1"}, q[1], e1);
            chk({tag, "_2"}, q[2], e2);
        end
    endtask

    // Runs the loaded profile after the capture clk; returns clks to done.
    task automatic play(output int n);
        n = 0;
        q0.delete(); q2.delete();
        while (!done && n < 60) begin
            cycle();
            n++;
            if (busy && !seg_first && seg == 3'd0) q0.push_back(speed);
            if (busy && !seg_first && seg == 3'd2) q2.push_back(speed);
        end
    endtask

    int n, pulses, seg1_clks, seg3_clks;

    initial begin
        reset = 1; start = 0; in_valid = 0; tick_en = 0;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        cycle(); cycle();
        reset = 0;
        cycle();

        // No capture without in_valid
        start = 1;
        load(3, 5, 8, 10, 1, 10, 2, 100);
        cycle(); cycle();
        chk("no_capture_busy", busy, 0);

        // Profile 1
        in_valid = 1; tick_en = 1;
        cycle();
        chk("t1_busy_rise", busy, 1);
        chk("t1_first", seg_first, 1);
        chk("t1_speed0", speed, 1);
        in_valid = 0;
        load(1, 1, 1, 1, 99, 99, 99, 7);
        play(n);
        chk("t1_clks", n, 14);
        chk("t1_elapsed", elapsed, 10);
        chk("t1_seg", seg, 4);
        chk("t1_steps", steps, 100);
        chk("t1_speed_end", speed, 1);
        chk_list("t1_seg0", q0, 3, 5, 7);
        chk_list("t1_seg2", q2, 5, 3, 1);
        cycle(); cycle();
        chk("t1_done_hold", done, 1);
        start = 0;
        cycle();
        chk("t1_done_clear", done, 0);

        // Profile 2: vmax clamp
        load(3, 5, 8, 10, 1, 4, 2, 55);
        start = 1; in_valid = 1;
        cycle();
        in_valid = 0;
        play(n);
        chk("t2_clks", n, 14);
        chk_list("t2_seg0", q0, 3, 4, 4);
        chk_list("t2_seg2", q2, 2, 1, 1);
        start = 0;
        cycle();

        // Profile 3: all zero-length segments
        load(0, 0, 0, 0, 5, 9, 1, 3);
        start = 1; in_valid = 1;
        cycle();
        pulses = seg_first;
        in_valid = 0; n = 0;
        while (!done && n < 20) begin cycle(); n++; pulses += seg_first; end
        chk("t3_pulses", pulses, 5);
        chk("t3_clks", n, 4);
        chk("t3_elapsed", elapsed, 0);
        chk("t3_speed", speed, 5);
        start = 0; cycle();

        // Profile 4: sparse ticks, skipped segments
        load(4, 4, 6, 6, 2, 20, 3, 9);
        start = 1; in_valid = 1; tick_en = 0;
        cycle();
        pulses = seg_first; seg1_clks = 0; seg3_clks = 0;
        in_valid = 0; n = 0;
        while (!done && n < 80) begin
            tick_en = (n % 3 == 2);
            cycle(); n++;
            pulses += seg_first;
            if (seg == 3'd1) seg1_clks++;
            if (seg == 3'd3) seg3_clks++;
        end
        chk("t4_pulses", pulses, 5);
        chk("t4_seg1_clks", seg1_clks, 1);
        chk("t4_seg3_clks", seg3_clks, 1);
        chk("t4_elapsed", elapsed, 6);
        chk("t4_speed", speed, 8);
        start = 0; tick_en = 1; cycle();

        // Abort at elapsed=2, then replay
        load(3, 5, 8, 10, 1, 10, 2, 100);
        start = 1; in_valid = 1;
        cycle();
        in_valid = 0; n = 0;
        while (elapsed != 2 && n < 20) begin cycle(); n++; end
        chk("t5_reach", elapsed, 2);
        start = 0;
        cycle();
        chk("t5_busy", busy, 0);
        chk("t5_seg", seg, 0);
        chk("t5_speed", speed, 0);
        start = 1; in_valid = 1;
        cycle();
        chk("t5_rebusy", busy, 1);
        chk("t5_refirst", seg_first, 1);
        chk("t5_respeed", speed, 1);
        in_valid = 0;
        play(n);
        chk("t5_clks", n, 14);

        // Reset in DONE then in RUN, recapture with start&&in_valid held
        reset = 1; in_valid = 1;
        cycle();
        chk("t6_done_rst", done, 0);
        chk("t6_seg_rst", seg, 0);
        reset = 0;
        cycle();
        chk("t6_recap1", busy, 1);
        cycle(); cycle(); cycle();
        reset = 1;
        cycle();
        chk("t6_run_rst_busy", busy, 0);
        chk("t6_run_rst_el", elapsed, 0);
        chk("t6_run_rst_speed", speed, 0);
        reset = 0;
        cycle();
        chk("t6_recap2", busy, 1);
        start = 0; in_valid = 0;
        cycle();

        // Randomized profiles
        for (int it = 0; it < 30; it++) begin
            longint tt [4];
            int unsigned vmin, vmax, acc;
            tt[0] = $urandom_range(0, 6);
            for (int k = 1; k < 4; k++) tt[k] = tt[k-1] + $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < 4; k++) tt[k] = $urandom_range(0, 15);
            vmin = $urandom_range(0, 50);
            vmax = $urandom_range(0, 100);
            acc  = $urandom_range(0, 30);
            if ($urandom_range(0, 4) == 0) begin
                vmax = 32'hFFFF_FFFF;
                vmin = 32'hFFFF_FF00 + $urandom_range(0, 200);
                acc  = 32'hF000_0000 + $urandom_range(0, 255);
            end
            load(tt[0], tt[1], tt[2], tt[3], vmin, vmax, acc, $urandom);
            start = 1; in_valid = 1; tick_en = $urandom_range(0, 1);
            cycle();
            n = 0;
            while (!done && n < 120) begin
                in_valid = $urandom_range(0, 1);
                tick_en  = $urandom_range(0, 1);
                if ($urandom_range(0, 59) == 0) start = 0;
                if (!start && $urandom_range(0, 1) == 0) begin start = 1; in_valid = 1; end
                load($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                     $urandom_range(0, 9), $urandom, $urandom, $urandom, $urandom);
                cycle(); n++;
            end
            chk("rnd_bounded", n < 120, 1);
            start = 0; in_valid = 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
